// File: rtl/softmax_sequencer_pkg.sv
// Shared state encoding and controller timing constants for the softmax sequencer.
package softmax_sequencer_pkg;

    typedef logic [4:0] seq_state_t;

    localparam seq_state_t IDLE  = 5'b00001;
    localparam seq_state_t LOAD  = 5'b00010;
    localparam seq_state_t RUN   = 5'b00100;
    localparam seq_state_t GAPW  = 5'b01000;
    localparam seq_state_t DRAIN = 5'b10000;

    // The controller holds stage 1 at least this long, which bounds VEC_LEN.
    localparam int unsigned STAGE1_MIN_LEN = 12;
    localparam int unsigned RUN_DONE_CNT   = 25;

endpackage

// File: rtl/softmax_vec_buf.sv
// Vector register file: one synchronous write port, one combinational read port.
module softmax_vec_buf #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned VEC_LEN = 8
) (
    input  logic                             i_clk,
    input  logic                             i_we,
    input  logic [$clog2(VEC_LEN + 1)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]                i_wdata,
    input  logic [$clog2(VEC_LEN + 1)-1:0]   i_raddr,
    output logic [DATA_W-1:0]                o_rdata
);

    localparam int unsigned PW = $clog2(VEC_LEN + 1);
    localparam int unsigned AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    logic [DATA_W-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_waddr < PW'(VEC_LEN))) begin
            r_mem[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    // Pointers reach VEC_LEN once a pass completes; reads there return zero.
    assign o_rdata = (i_raddr < PW'(VEC_LEN)) ? r_mem[i_raddr[AW-1:0]] : '0;

endmodule

// File: rtl/softmax_sequencer.sv
// Initiator-side sequencer: loads one vector, drives one softmax controller run, drains results.
module softmax_sequencer
    import softmax_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_softmax_en,
    input  logic              i_is_stage1,
    input  logic              i_is_stage2,
    input  logic              i_is_stage3,
    input  logic              i_is_stage4,
    output logic              o_sm_in_valid,
    output logic [DATA_W-1:0] o_sm_in_data,
    input  logic              i_sm_out_valid,
    input  logic [DATA_W-1:0] i_sm_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned PW = $clog2(VEC_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(VEC_LEN - 1);
    localparam logic [PW-1:0] VEC_END  = PW'(VEC_LEN);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    if (VEC_LEN < 1 || VEC_LEN > STAGE1_MIN_LEN) begin : g_bad_vec_len
        $error("VEC_LEN must lie in 1..%0d", STAGE1_MIN_LEN);
    end

    seq_state_t        r_state, w_state_d;
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_cap_ptr, r_out_ptr, w_cap_cnt;
    logic [TW-1:0]     r_tmo, w_tmo_next;
    logic [GW-1:0]     r_gap;
    logic              r_busy, r_softmax_en, r_sm_in_valid, r_done, r_err;
    logic              r_seen4, r_s1_q, r_s4_q, r_abort;
    logic [DATA_W-1:0] r_sm_in_data, w_op_rdata, w_res_rdata;
    logic              w_load_xfer, w_load_last, w_in_run, w_feed, w_res_valid, w_cap;
    logic              w_s1_fall, w_s4_fall, w_abort, w_run_ok, w_gap_end, w_out_xfer, w_out_end;
    logic              w_unused_stage;

    assign w_unused_stage = i_is_stage2 ^ i_is_stage3;

    always_comb begin
        w_load_xfer = (r_state == LOAD) && i_in_valid;
        w_load_last = w_load_xfer && (r_wr_ptr == LAST_IDX);
        w_in_run    = (r_state == RUN);
        w_feed      = w_in_run && i_is_stage1 && (r_rd_ptr < VEC_END);
        w_res_valid = w_in_run && i_is_stage4 && i_sm_out_valid;
        w_cap       = w_res_valid && (r_cap_ptr < VEC_END);
        w_cap_cnt   = r_cap_ptr + PW'(w_cap);
        w_s1_fall   = r_s1_q && !i_is_stage1;
        w_s4_fall   = r_s4_q && !i_is_stage4;
        w_tmo_next  = r_tmo + TW'(1);
        // A capture landing together with the stage-4 fall still counts toward the total.
        w_abort     = w_in_run && ((w_s1_fall && (r_rd_ptr < VEC_END))
                                || (w_res_valid && (r_cap_ptr == VEC_END))
                                || (w_s4_fall && (w_cap_cnt < VEC_END))
                                || (w_tmo_next == TMO_END));
        w_run_ok    = w_in_run && !w_abort && r_seen4 && w_s4_fall;
        w_gap_end   = (r_state == GAPW) && (r_gap == GAP_LAST);
        w_out_xfer  = (r_state == DRAIN) && i_out_ready;
        w_out_end   = w_out_xfer && (r_out_ptr == LAST_IDX);

        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_d = LOAD;
            LOAD:    if (w_load_last) w_state_d = RUN;
            RUN:     if (w_abort || w_run_ok) w_state_d = GAPW;
            GAPW:    if (w_gap_end) w_state_d = r_abort ? IDLE : DRAIN;
            DRAIN:   if (w_out_end) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_softmax_en  <= 1'b0;
            r_sm_in_valid <= 1'b0;
            r_sm_in_data  <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cap_ptr     <= '0;
            r_out_ptr     <= '0;
            r_tmo         <= '0;
            r_gap         <= '0;
            r_seen4       <= 1'b0;
            r_s1_q        <= 1'b0;
            r_s4_q        <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_busy        <= (w_state_d != IDLE);
            r_err         <= w_abort;
            r_done        <= w_out_end;
            r_sm_in_valid <= w_feed;
            if (w_feed) r_sm_in_data <= w_op_rdata;

            if ((r_state == IDLE) && i_start) r_wr_ptr <= '0;
            else if (w_load_xfer) r_wr_ptr <= r_wr_ptr + PW'(1);

            if (w_load_last) begin
                r_softmax_en <= 1'b1;
                r_rd_ptr     <= '0;
                r_cap_ptr    <= '0;
                r_tmo        <= '0;
                r_seen4      <= 1'b0;
                r_s1_q       <= 1'b0;
                r_s4_q       <= 1'b0;
            end

            if (w_in_run) begin
                r_tmo  <= w_tmo_next;
                r_s1_q <= i_is_stage1;
                r_s4_q <= i_is_stage4;
                if (i_is_stage4) r_seen4 <= 1'b1;
                if (w_feed) r_rd_ptr <= r_rd_ptr + PW'(1);
                if (w_cap) r_cap_ptr <= w_cap_cnt;
                if (w_abort || w_run_ok) begin
                    r_softmax_en <= 1'b0;
                    r_abort      <= w_abort;
                    r_gap        <= '0;
                end
            end

            if (r_state == GAPW) r_gap <= r_gap + GW'(1);
            if (w_gap_end) r_out_ptr <= '0;
            else if (w_out_xfer) r_out_ptr <= r_out_ptr + PW'(1);
        end
    end

    softmax_vec_buf #(
        .DATA_W  (DATA_W),
        .VEC_LEN (VEC_LEN)
    ) u_op_buf (
        .i_clk   (i_clk),
        .i_we    (w_load_xfer),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_op_rdata)
    );

    softmax_vec_buf #(
        .DATA_W  (DATA_W),
        .VEC_LEN (VEC_LEN)
    ) u_res_buf (
        .i_clk   (i_clk),
        .i_we    (w_cap),
        .i_waddr (r_cap_ptr),
        .i_wdata (i_sm_out_data),
        .i_raddr (r_out_ptr),
        .o_rdata (w_res_rdata)
    );

    assign o_busy        = r_busy;
    assign o_softmax_en  = r_softmax_en;
    assign o_sm_in_valid = r_sm_in_valid;
    assign o_sm_in_data  = r_sm_in_data;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_in_ready    = (r_state == LOAD);
    assign o_out_valid   = (r_state == DRAIN);
    assign o_out_data    = o_out_valid ? w_res_rdata : '0;
    assign o_out_last    = o_out_valid && (r_out_ptr == LAST_IDX);

endmodule

// File: tb/tb_softmax_sequencer.sv
// Scoreboard bench for softmax_sequencer with a behavioural controller and x+100 datapath.
module tb_softmax_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [15:0] in_data;
    logic        busy, in_ready, softmax_en, sm_in_valid, out_valid, out_last, done, err;
    logic [15:0] sm_in_data, out_data, sm_out_data;
    logic        is_stage1, is_stage2, is_stage3, is_stage4, sm_out_valid;

    always #5 clk = ~clk;

    softmax_sequencer u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .o_busy         (busy),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_data      (in_data),
        .o_softmax_en   (softmax_en),
        .i_is_stage1    (is_stage1),
        .i_is_stage2    (is_stage2),
        .i_is_stage3    (is_stage3),
        .i_is_stage4    (is_stage4),
        .o_sm_in_valid  (sm_in_valid),
        .o_sm_in_data   (sm_in_data),
        .i_sm_out_valid (sm_out_valid),
        .i_sm_out_data  (sm_out_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_data     (out_data),
        .o_out_last     (out_last),
        .o_done         (done),
        .o_err          (err)
    );

    // Controller model: stage 1 = 0..11, 2 = 12..13, 3 = 14..15, 4 = 16..24, idle from 25.
    logic [5:0]  ctl_cnt = '0;
    logic [5:0]  k;
    logic [15:0] op_rec [16];
    logic [4:0]  op_cnt = '0;
    bit          stuck = 1'b0;
    int          nres  = 8;

    always @(posedge clk) begin
        if (!softmax_en) ctl_cnt <= '0;
        else if (!(stuck && ctl_cnt == 6'd12) && ctl_cnt < 6'd40) ctl_cnt <= ctl_cnt + 6'd1;
        if (!softmax_en) op_cnt <= '0;
        else if (sm_in_valid && op_cnt < 5'd16) begin
            op_rec[op_cnt[3:0]] <= sm_in_data;
            op_cnt <= op_cnt + 5'd1;
        end
    end

    assign is_stage1    = softmax_en && (ctl_cnt < 6'd12);
    assign is_stage2    = softmax_en && (ctl_cnt >= 6'd12) && (ctl_cnt < 6'd14);
    assign is_stage3    = softmax_en && (ctl_cnt >= 6'd14) && (ctl_cnt < 6'd16);
    assign is_stage4    = softmax_en && (ctl_cnt >= 6'd16) && (ctl_cnt < 6'd25);
    assign k            = ctl_cnt - 6'd16;
    assign sm_out_valid = is_stage4 && (int'(k) < nres);
    assign sm_out_data  = op_rec[k[3:0]] + 16'd100;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_op [$];
    logic [16:0] exp_out [$];

    int  done_cnt = 0, err_cnt = 0, out_xfers = 0, ov_cnt = 0, hold_cnt = 0;
    int  en_len = 0, last_en_len = 0, en_low = 0, err_gap = 0, last_err_gap = 0;
    bit  en_prev = 1'b0, seen_run = 1'b0, err_armed = 1'b0;
    bit  bp_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic        prev_hold = 1'b0;
        logic [15:0] prev_data = '0;
        logic [15:0] eo;
        logic [16:0] ex;
        forever begin
            @(negedge clk);
            if (sm_in_valid) begin
                if (exp_op.size() > 0) begin
                    eo = exp_op.pop_front();
                    check("sm_in_data", 64'(sm_in_data), 64'(eo));
                end else check("sm_in_unexpected", 64'(sm_in_valid), 64'd0);
            end
            if (out_valid) begin
                ov_cnt++;
                if (prev_hold) begin
                    hold_cnt++;
                    check("out_hold", 64'(out_data), 64'(prev_data));
                end
                if (out_ready) begin
                    out_xfers++;
                    if (exp_out.size() > 0) begin
                        ex = exp_out.pop_front();
                        check("out_elem", 64'({out_last, out_data}), 64'(ex));
                    end else check("out_unexpected", 64'(out_valid), 64'd0);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (done) done_cnt++;
            if (err_armed) begin
                if (busy) err_gap++;
                else begin
                    err_armed    = 1'b0;
                    last_err_gap = err_gap;
                end
            end
            if (err) begin
                err_cnt++;
                check("err_en_low", 64'(softmax_en), 64'd0);
                err_armed = 1'b1;
                err_gap   = 1;
            end
            if (softmax_en) begin
                if (!en_prev) begin
                    if (seen_run) check("en_gap_min2", 64'(en_low >= 2), 64'd1);
                    seen_run = 1'b1;
                    en_len   = 0;
                end
                en_len++;
                en_low = 0;
            end else begin
                if (en_prev) last_en_len = en_len;
                en_low++;
            end
            en_prev = softmax_en;
        end
    endtask

    task automatic rdy_driver();
        int i = 0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
            i++;
        end
    endtask

    task automatic run_vec(input logic [15:0] base, input bit bubbly, input bit ok);
        int idx = 0;
        int t   = 0;
        bit v;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < 8 && t < 100) begin
            v        = bubbly ? ((t % 5) != 1 && (t % 5) != 4) : 1'b1;
            in_valid = v;
            in_data  = base + 16'(idx);
            start    = bubbly && ((t % 3) == 2);
            @(negedge clk);
            if (v && in_ready) begin
                exp_op.push_back(base + 16'(idx));
                if (ok) exp_out.push_back({idx == 7, base + 16'(idx) + 16'd100});
                idx++;
            end
            @(posedge clk); #1;
            t++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hdead;
        @(negedge clk);
        check("in_ready_after_load", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("load_count", 64'(idx), 64'd8);
    endtask

    task automatic wait_idle(input int max_cyc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < max_cyc);
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({busy, in_ready, softmax_en, sm_in_valid, sm_in_data, out_valid,
                    out_data, out_last, done, err});
    endfunction

    int d0, e0, x0, v0, h0, w;

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        fork
            monitor();
            rdy_driver();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Nominal run.
        d0 = done_cnt; e0 = err_cnt; x0 = out_xfers;
        run_vec(16'd1, 1'b0, 1'b1);
        wait_idle(200);
        check("nom_done", 64'(done_cnt - d0), 64'd1);
        check("nom_err", 64'(err_cnt - e0), 64'd0);
        check("nom_xfers", 64'(out_xfers - x0), 64'd8);
        check("nom_en_len", 64'(last_en_len), 64'd26);
        check("nom_queues", 64'(exp_out.size() + exp_op.size()), 64'd0);

        // Backpressure on the drain.
        bp_mode = 1'b1;
        d0 = done_cnt; x0 = out_xfers; h0 = hold_cnt;
        run_vec(16'h20, 1'b0, 1'b1);
        wait_idle(300);
        bp_mode = 1'b0;
        check("bp_done", 64'(done_cnt - d0), 64'd1);
        check("bp_xfers", 64'(out_xfers - x0), 64'd8);
        check("bp_holds_seen", 64'(hold_cnt > h0), 64'd1);
        check("bp_queue", 64'(exp_out.size()), 64'd0);

        // Datapath returns only seven results.
        nres = 7;
        d0 = done_cnt; e0 = err_cnt; v0 = ov_cnt;
        run_vec(16'h40, 1'b0, 1'b0);
        wait_idle(200);
        nres = 8;
        check("short_err", 64'(err_cnt - e0), 64'd1);
        check("short_no_done", 64'(done_cnt - d0), 64'd0);
        check("short_no_drain", 64'(ov_cnt - v0), 64'd0);
        check("short_gap", 64'(last_err_gap), 64'd2);

        // Controller stuck in stage 2.
        stuck = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        run_vec(16'h60, 1'b0, 1'b0);
        wait_idle(300);
        stuck = 1'b0;
        check("tmo_err", 64'(err_cnt - e0), 64'd1);
        check("tmo_en_len", 64'(last_en_len), 64'd64);
        check("tmo_no_done", 64'(done_cnt - d0), 64'd0);
        check("tmo_gap", 64'(last_err_gap), 64'd2);

        // Reset on the fifth stage-1 cycle.
        run_vec(16'h80, 1'b0, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(is_stage1 && ctl_cnt == 6'd4) && w < 50);
        check("rst_reached_stage1", 64'(is_stage1), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", out_vec(), 64'd0);
        rst = 1'b1;
        exp_op.delete();

        d0 = done_cnt; e0 = err_cnt; x0 = out_xfers;
        run_vec(16'h90, 1'b0, 1'b1);
        wait_idle(200);
        check("post_rst_done", 64'(done_cnt - d0), 64'd1);
        check("post_rst_err", 64'(err_cnt - e0), 64'd0);
        check("post_rst_xfers", 64'(out_xfers - x0), 64'd8);

        // Bubbly load with stray start pulses.
        d0 = done_cnt; x0 = out_xfers;
        run_vec(16'ha0, 1'b1, 1'b1);
        wait_idle(200);
        check("bubbly_done", 64'(done_cnt - d0), 64'd1);
        check("bubbly_xfers", 64'(out_xfers - x0), 64'd8);
        check("bubbly_queues", 64'(exp_out.size() + exp_op.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/softmax_sequencer.md
Name: softmax_sequencer

Overview:
- Initiator-side counterpart to the softmax stage controller. Buffers one VEC_LEN-element input vector and holds softmax_en high for exactly one controller run.
- Tracks the controller's is_stage1..is_stage4 outputs. Streams operands to the softmax datapath during stage 1 and captures results during stage 4.
- Drains captured results to the downstream consumer over valid/ready, then pulses done.
- Sits between the attention scheduler and the softmax unit.

Parameters:
- DATA_W, 16: element width, fixed-point, passed through untouched.
- VEC_LEN, 8: elements per vector. Must satisfy 1 <= VEC_LEN <= 12, because stage 1 is at least 12 cycles.
- TIMEOUT, 64: maximum cycles in RUN before abort.
- GAP, 2: minimum low cycles of softmax_en between runs, so the controller counter clears.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset. Sampled on posedge clk; asserted when 0.
- start  input  1  one-cycle request to begin loading a vector. Honoured only in IDLE.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  input element valid.
- in_ready  output  1  high only in LOAD.
- in_data  input  DATA_W  input element.
- softmax_en  output  1  run enable to the softmax controller.
- is_stage1, is_stage2, is_stage3, is_stage4  input  1 each  controller stage flags.
- sm_in_valid  output  1  operand valid to the datapath.
- sm_in_data  output  DATA_W  operand to the datapath.
- sm_out_valid  input  1  result valid from the datapath.
- sm_out_data  input  DATA_W  result from the datapath.
- out_valid  output  1  result element valid.
- out_ready  input  1  consumer ready.
- out_data  output  DATA_W  result element.
- out_last  output  1  high with the final element of the vector.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on abort.

Behaviour:
- Reset (rst==0): state=IDLE. All pointers and counters cleared. Every output is 0 (busy, in_ready, softmax_en, sm_in_valid, sm_in_data, out_valid, out_data, out_last, done, err). Buffer contents are don't-care. Reset mid-run deasserts softmax_en on the next edge.
- All outputs are registered except in_ready, out_valid, out_data and out_last, which decode directly from state and pointer registers.
- IDLE: when start==1 go to LOAD and clear wr_ptr.
- LOAD:
  - A transfer happens on in_valid && in_ready. The element is written to buf[wr_ptr] and wr_ptr increments.
  - After element VEC_LEN-1 is accepted, go to RUN. in_ready is low from that edge on.
  - start is ignored outside IDLE.
- RUN:
  - softmax_en=1 from the first RUN cycle. Clear rd_ptr, cap_ptr and the timeout counter.
  - Feed: on each cycle with is_stage1==1 and rd_ptr<VEC_LEN, drive sm_in_valid=1 and sm_in_data=buf[rd_ptr] (registered, one cycle later), then increment rd_ptr. sm_in_valid is 0 otherwise.
  - Capture: on each cycle with is_stage4==1 and sm_out_valid==1, write sm_out_data to res[cap_ptr] and increment cap_ptr.
  - sm_out_valid outside stage 4 is ignored.
  - Track seen4 (is_stage4 observed high). Falling edge of is_stage4 after seen4 leads to GAPW.
- Abort conditions, checked every cycle in RUN:
  - is_stage1 falls while rd_ptr<VEC_LEN.
  - sm_out_valid in stage 4 with cap_ptr==VEC_LEN (overflow).
  - is_stage4 falls with cap_ptr<VEC_LEN.
  - Timeout counter reaches TIMEOUT.
- On abort: err=1 for one cycle, softmax_en=0, go to GAPW with an abort flag set.
- GAPW:
  - softmax_en=0 for exactly GAP cycles.
  - Then go to DRAIN on normal completion, or to IDLE on abort.
  - busy stays high throughout.
- DRAIN:
  - out_valid=1, out_data=res[out_ptr], out_last=(out_ptr==VEC_LEN-1).
  - A transfer on out_valid && out_ready increments out_ptr.
  - out_data is held stable while out_ready==0.
  - The last transfer leads to IDLE with done=1 for one cycle.
- Simultaneous: capture of the final element and the falling edge of is_stage4 in the same cycle count as success.
- Pointer widths are $clog2(VEC_LEN+1) bits. None of the pointers wrap.

Decomposition:
- Shared softmax package holds:
  - state encoding, one-hot localparams: IDLE, LOAD, RUN, GAPW, DRAIN;
  - the stage-1 minimum length constant, 12;
  - the run-complete count, 25.
- One sub-module: softmax_vec_buf, a VEC_LEN x DATA_W register file with one write and one read port. It is instantiated twice, for the operand buffer and the result buffer.

Test Plan:
- Nominal: start; load 1..8 with in_valid continuous. Behavioural controller model; datapath returns x+100 in stage 4. Expect:
  - softmax_en high until is_stage4 falls;
  - sm_in_data 1..8 on consecutive stage-1 cycles;
  - out_data 101..108 with out_last on 108;
  - done pulses once;
  - softmax_en low for 2 cycles before any new run.
- Backpressure: out_ready toggles 1,0,0,1. Expect out_data stable while ready is low, no loss or duplication, and 8 transfers total.
- Short result: datapath returns only 7 results, then is_stage4 falls. Expect err pulse, no done, no DRAIN, return to IDLE after GAP.
- Timeout: controller model stuck in STAGE2. Expect err at RUN cycle 64 and softmax_en=0 on the next edge.
- Reset mid-RUN: rst=0 on cycle 5 of stage 1. Expect all outputs 0 the next edge and state IDLE. A subsequent start runs cleanly.
- Bubbly load: in_valid pattern 1,0,1,1,0,... Expect exactly 8 accepted, in order; start pulses during LOAD are ignored.
